coin_front_end: RTL and testbench

// Upstream input stage of VendingMachine. Synchronises and debounces the raw coin sensors and item keys.

---
 rtl/vend_pkg.sv | 21 ++
 rtl/debounce_edge.sv | 59 +++++
 rtl/coin_front_end.sv | 143 ++++++++++++++
 tb/tb_coin_front_end.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and item encodings for the vending machine front end and payment logic.
package vend_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        SELECTED = 1'b1
    } fe_state_t;

    localparam logic [3:0] ITEM1 = 4'b0001;
    localparam logic [3:0] ITEM2 = 4'b0010;
    localparam logic [3:0] ITEM3 = 4'b0100;
    localparam logic [3:0] ITEM4 = 4'b1000;

    localparam int NUM_KEYS = 4;

    // True when exactly one key bit is set.
    function automatic logic is_one_hot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/debounce_edge.sv
// Two-flop synchroniser, stability counter and rising-edge detect for one raw input.
module debounce_edge #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive synced samples that disagree with the accepted level; any agreeing sample clears it.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else if (cnt_q < CNT_W'(DEBOUNCE_CYCLES)) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // Synchroniser, counter, level and one-cycle rise pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/coin_front_end.sv
// Coin/key front end: debounces all sensors, tracks item selection and emits coin, reject and refund pulses.
module coin_front_end #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw_five,
    input  logic       raw_ten,
    input  logic [3:0] raw_key,
    input  logic       raw_cancel,
    input  logic       product,
    output logic [3:0] item_no,
    output logic       five_rup,
    output logic       ten_rup,
    output logic       coin_reject,
    output logic       refund_req
);

    import vend_pkg::*;

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    // Input bit order: [0] five, [1] ten, [5:2] keys, [6] cancel.
    logic [6:0] raw_vec;
    logic [6:0] rise_vec;
    logic [6:0] level_unused;

    assign raw_vec = {raw_cancel, raw_key, raw_ten, raw_five};

    for (genvar i = 0; i < 7; i++) begin : g_db
        debounce_edge #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (raw_vec[i]),
            .level(level_unused[i]),
            .rise (rise_vec[i])
        );
    end

    logic       five_rise, ten_rise, cancel_rise, any_coin, exit_now;
    logic [3:0] key_rise;

    assign five_rise   = rise_vec[0];
    assign ten_rise    = rise_vec[1];
    assign key_rise    = rise_vec[5:2];
    assign cancel_rise = rise_vec[6];
    assign any_coin    = five_rise | ten_rise;

    fe_state_t  state_q, state_d;
    logic [3:0] item_q, item_d;
    logic       credit_q, credit_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic       five_q, five_d;
    logic       ten_q, ten_d;
    logic       reject_q, reject_d;
    logic       refund_q, refund_d;

    // Next state and registered pulses; exit priority is product, then cancel, then timeout, then coin.
    always_comb begin
        state_d  = state_q;
        item_d   = item_q;
        credit_d = credit_q;
        tmo_d    = tmo_q;
        five_d   = 1'b0;
        ten_d    = 1'b0;
        reject_d = 1'b0;
        refund_d = 1'b0;
        exit_now = 1'b0;
        case (state_q)
            IDLE: begin
                reject_d = any_coin;
                if (is_one_hot4(key_rise)) begin
                    state_d  = SELECTED;
                    item_d   = key_rise;
                    credit_d = 1'b0;
                    tmo_d    = '0;
                end
            end
            SELECTED: begin
                if (product) begin
                    exit_now = 1'b1;
                end else if (cancel_rise || (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1))) begin
                    exit_now = 1'b1;
                    refund_d = credit_q;
                end
                if (exit_now) begin
                    state_d  = IDLE;
                    item_d   = 4'b0000;
                    credit_d = 1'b0;
                    tmo_d    = '0;
                    reject_d = any_coin;
                end else if (five_rise && ten_rise) begin
                    reject_d = 1'b1;
                    if (tmo_q != TMO_W'(TIMEOUT_CYCLES)) tmo_d = tmo_q + 1'b1;
                end else if (any_coin) begin
                    five_d   = five_rise;
                    ten_d    = ten_rise;
                    credit_d = 1'b1;
                    tmo_d    = '0;
                end else begin
                    if (tmo_q != TMO_W'(TIMEOUT_CYCLES)) tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                item_d  = 4'b0000;
            end
        endcase
    end

    // FSM state, selection, credit flag, timeout counter and output pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            item_q   <= 4'b0000;
            credit_q <= 1'b0;
            tmo_q    <= '0;
            five_q   <= 1'b0;
            ten_q    <= 1'b0;
            reject_q <= 1'b0;
            refund_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            item_q   <= item_d;
            credit_q <= credit_d;
            tmo_q    <= tmo_d;
            five_q   <= five_d;
            ten_q    <= ten_d;
            reject_q <= reject_d;
            refund_q <= refund_d;
        end
    end

    assign item_no     = item_q;
    assign five_rup    = five_q;
    assign ten_rup     = ten_q;
    assign coin_reject = reject_q;
    assign refund_req  = refund_q;

endmodule

// File: tb/tb_coin_front_end.sv
// Self-checking bench for coin_front_end: directed scenarios plus random bouncing inputs against a reference model.
module tb_coin_front_end;

    localparam int DEB = 4;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       raw_five = 1'b0;
    logic       raw_ten = 1'b0;
    logic [3:0] raw_key = 4'b0000;
    logic       raw_cancel = 1'b0;
    logic       product = 1'b0;
    logic [3:0] item_no;
    logic       five_rup, ten_rup, coin_reject, refund_req;

    coin_front_end #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_five   (raw_five),
        .raw_ten    (raw_ten),
        .raw_key    (raw_key),
        .raw_cancel (raw_cancel),
        .product    (product),
        .item_no    (item_no),
        .five_rup   (five_rup),
        .ten_rup    (ten_rup),
        .coin_reject(coin_reject),
        .refund_req (refund_req)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int n_five, n_ten, n_rej, n_ref;
    int first_five;
    int cyc_idx;

    // Reference model state: raw sample log per clock edge, accepted levels, pending rises, selection.
    logic [6:0] raw_log[$];
    bit         m_lvl[7];
    bit         m_pend[7];
    logic [3:0] m_item;
    bit         m_credit;
    int         m_idle;
    logic [7:0] m_out;

    task automatic model_reset();
        raw_log.delete();
        for (int i = 0; i < 7; i++) begin
            m_lvl[i]  = 1'b0;
            m_pend[i] = 1'b0;
        end
        m_item   = 4'b0000;
        m_credit = 1'b0;
        m_idle   = 0;
        m_out    = 8'h00;
    endtask

    task automatic model_step();
        bit         f, t, c, any_c, leave, all_diff, s;
        logic [3:0] kr;
        bit         e5, e10, erj, erf;
        int         idx;
        f = m_pend[0];
        t = m_pend[1];
        kr = {m_pend[5], m_pend[4], m_pend[3], m_pend[2]};
        c = m_pend[6];
        any_c = f | t;
        e5 = 0; e10 = 0; erj = 0; erf = 0;
        if (m_item == 4'b0000) begin
            erj = any_c;
            if ($countones(kr) == 1) begin
                m_item   = kr;
                m_idle   = 0;
                m_credit = 0;
            end
        end else begin
            leave = product || c || (m_idle >= TMO - 1);
            if (leave) begin
                erf      = !product && m_credit;
                erj      = any_c;
                m_item   = 4'b0000;
                m_credit = 0;
                m_idle   = 0;
            end else if (f && t) begin
                erj = 1;
                m_idle++;
            end else if (any_c) begin
                e5       = f;
                e10      = t;
                m_credit = 1;
                m_idle   = 0;
            end else begin
                m_idle++;
            end
        end
        m_out = {m_item, e5, e10, erj, erf};
        // A level is accepted once the last DEB samples seen through the 2-cycle synchroniser all oppose it.
        raw_log.push_back({raw_cancel, raw_key, raw_ten, raw_five});
        if (raw_log.size() > 32) void'(raw_log.pop_front());
        for (int i = 0; i < 7; i++) begin
            all_diff = 1;
            for (int j = 0; j < DEB; j++) begin
                idx = raw_log.size() - 3 - j;
                s = (idx >= 0) ? raw_log[idx][i] : 1'b0;
                if (s == m_lvl[i]) all_diff = 0;
            end
            m_pend[i] = all_diff && !m_lvl[i];
            if (all_diff) m_lvl[i] = ~m_lvl[i];
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        @(negedge clk);
        cyc_idx++;
        tests++;
        assert ({item_no, five_rup, ten_rup, coin_reject, refund_req} === m_out) else begin
            fails++;
            $error("FAIL model_cycle t=%0t observed=%b expected=%b", $time,
                   {item_no, five_rup, ten_rup, coin_reject, refund_req}, m_out);
        end
        if (five_rup === 1'b1) begin
            n_five++;
            if (first_five < 0) first_five = cyc_idx;
        end
        if (ten_rup === 1'b1) n_ten++;
        if (coin_reject === 1'b1) n_rej++;
        if (refund_req === 1'b1) n_ref++;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic clr();
        n_five = 0; n_ten = 0; n_rej = 0; n_ref = 0;
        first_five = -1;
        cyc_idx = 0;
    endtask

    initial begin
        model_reset();
        clr();
        // Reset state
        run(3);
        check("reset_item", item_no, 4'b0000);
        check("reset_pulses", {five_rup, ten_rup, coin_reject, refund_req}, 4'b0000);
        rst_n = 1'b1;
        run(4);

        // Select item3 and pay with two 10-rupee coins, then vend
        raw_key = 4'b0100;
        run(8);
        check("sel_item3", item_no, 4'b0100);
        raw_key = 4'b0000; raw_ten = 1'b1; clr();
        run(8);
        raw_ten = 1'b0;
        run(5);
        raw_ten = 1'b1;
        run(8);
        check("pay_ten_count", n_ten, 2);
        check("pay_no_reject", n_rej + n_five, 0);
        product = 1'b1;
        cyc();
        product = 1'b0;
        check("vend_item_cleared", item_no, 4'b0000);
        raw_ten = 1'b0;
        run(8);
        check("vend_no_refund", n_ref, 0);

        // Coin with nothing selected
        raw_ten = 1'b1; clr();
        run(8);
        check("idle_coin_reject", n_rej, 1);
        check("idle_coin_no_ten", n_ten, 0);
        raw_ten = 1'b0;
        run(6);

        // Both coins rising together while selected
        raw_key = 4'b0001;
        run(8);
        check("sel_item1", item_no, 4'b0001);
        raw_key = 4'b0000; raw_five = 1'b1; raw_ten = 1'b1; clr();
        run(8);
        check("dual_coin_reject", n_rej, 1);
        check("dual_coin_no_rupee", n_five + n_ten, 0);
        raw_five = 1'b0; raw_ten = 1'b0;
        run(20);
        check("dual_timeout_idle", item_no, 4'b0000);
        check("dual_no_refund", n_ref, 0);

        // Bouncing five sensor: only the final stable hold is accepted, six cycles later
        for (int i = 0; i < 10; i++) begin
            raw_key  = 4'b0001;
            raw_five = (i % 2 == 0);
            cyc();
        end
        check("bounce_selected", item_no, 4'b0001);
        raw_five = 1'b1; clr();
        run(10);
        check("bounce_one_pulse", n_five, 1);
        check("bounce_latency", first_five, 7);
        raw_ten = 1'b1; clr();
        run(3);
        raw_ten = 1'b0;
        run(8);
        check("glitch_no_pulse", n_ten + n_rej, 0);
        raw_key = 4'b0000; raw_five = 1'b0;
        run(20);

        // Cancel with credit refunds; timeout without credit does not
        raw_key = 4'b0001;
        run(8);
        raw_key = 4'b0000; raw_five = 1'b1; clr();
        run(8);
        check("cancel_five_count", n_five, 1);
        raw_five = 1'b0; raw_cancel = 1'b1; clr();
        run(8);
        check("cancel_refund_once", n_ref, 1);
        check("cancel_item_cleared", item_no, 4'b0000);
        raw_cancel = 1'b0;
        run(6);
        raw_key = 4'b0010;
        run(8);
        check("sel_item2", item_no, 4'b0010);
        raw_key = 4'b0000; clr();
        run(8);
        check("timeout_not_yet", item_no, 4'b0010);
        run(10);
        check("timeout_item_cleared", item_no, 4'b0000);
        check("timeout_no_refund", n_ref, 0);

        // Key rules
        raw_key = 4'b0011;
        run(8);
        check("two_keys_ignored", item_no, 4'b0000);
        raw_key = 4'b0000;
        run(6);
        raw_key = 4'b0001;
        run(8);
        raw_key = 4'b1000;
        run(8);
        check("key_frozen", item_no, 4'b0001);
        raw_key = 4'b0000;
        run(20);

        // Asynchronous reset mid-payment with a coin still in the debouncer
        raw_key = 4'b0100;
        run(8);
        check("presel_item3", item_no, 4'b0100);
        raw_key = 4'b0000; raw_five = 1'b1;
        run(4);
        rst_n = 1'b0; raw_five = 1'b0;
        #1;
        check("async_reset_item", item_no, 4'b0000);
        check("async_reset_pulses", {five_rup, ten_rup, coin_reject, refund_req}, 4'b0000);
        run(3);
        rst_n = 1'b1; clr();
        run(10);
        check("post_reset_idle", item_no, 4'b0000);
        check("post_reset_no_pulse", n_five + n_rej + n_ref, 0);

        // Random bouncing inputs, one reset in the middle
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) raw_five = ~raw_five;
            if ($urandom_range(0, 6) == 0) raw_ten = ~raw_ten;
            if ($urandom_range(0, 9) == 0) raw_cancel = ~raw_cancel;
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 11) == 0) raw_key[k] = ~raw_key[k];
            product = ($urandom_range(0, 29) == 0);
            if (n == 1500) rst_n = 1'b0;
            if (n == 1503) rst_n = 1'b1;
            cyc();
        end
        product = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
